// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler time-sharing one serial Moore "1011" detector among N requesters.
// Define SEQ_SCHED_FIXED_PRIORITY_EN for fixed priority (lowest index wins, ptr held at 0).
module seq_detect_scheduler #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] data_i,
  output logic [N-1:0]   grant_o,
  output logic           done_o,
  output logic [CW-1:0]  hit_count_o,
  output logic           match_any_o,
  output logic           det_seq_in_o,
  output logic           det_reset_o,
  input  logic           det_out_i
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] hit_q, hit_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d;

  logic [W-1:0]  words [N];
  logic          found;
  logic [PW-1:0] pick;
  int            cidx;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign words[g] = data_i[g*W +: W];
  end

  // Scan requesters starting at ptr, wrapping; first asserted one wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cidx  = 0;
    for (int i = 0; i < N; i++) begin
      cidx = int'(ptr_q) + i;
      if (cidx >= N) cidx = cidx - N;
      if (!found && req_i[PW'(cidx)]) begin
        found = 1'b1;
        pick  = PW'(cidx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sh_d         = sh_q;
    bit_d        = bit_q;
    hit_d        = hit_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    done_o       = 1'b0;
    det_reset_o  = 1'b0;
    det_seq_in_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = CLEAR;
          win_d   = pick;
          sh_d    = words[pick];
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
        end
      end
      CLEAR: begin
        det_reset_o = 1'b1;
        bit_d       = '0;
        hit_d       = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        det_seq_in_o = sh_q[W-1];
        sh_d         = {sh_q[W-2:0], 1'b0};
        bit_d        = bit_q + 1'b1;
        if (det_out_i && (hit_q != '1)) hit_d = hit_q + 1'b1;
        if (bit_q == BW'(W - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Catches a match completed by the final shifted bit.
        if (det_out_i && (hit_q != '1)) hit_d = hit_q + 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        grant_d = '0;
`ifdef SEQ_SCHED_FIXED_PRIORITY_EN
        ptr_d   = '0;
`else
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      hit_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      hit_q   <= hit_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign grant_o     = grant_q;
  assign hit_count_o = hit_q;
  assign match_any_o = |hit_q;
endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Round-robin scheduler that time-shares one serial Moore "1011" sequence detector among N parallel requesters. Each requester submits a W-bit word. The scheduler clears the detector, shifts the granted word in MSB-first, samples the detector output, and returns the overlapping-match count to the granted requester with a done pulse. It sits between requesting blocks and the single detector instance, and owns that detector's sequence input and clear.

## Interface
- N, 4: number of requesters (2..8).
- W, 8: word width in bits (≥4).
- CW, 4: hit_count width; count saturates at 2^CW−1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clock clock.
- req  in  N  per-requester request level.
- data  in  N*W  flattened words; requester i occupies bits [i*W+W-1 : i*W].
- grant  out  N  one-hot, registered; held for the whole transaction.
- done  out  1  one-cycle pulse; result valid in this cycle.
- hit_count  out  CW  matches found in the granted word.
- match_any  out  1  high when hit_count ≠ 0, valid with done.
- det_seq_in  out  1  serial bit to the detector's sequence input.
- det_reset  out  1  clear pulse to the detector's reset input.
- det_out  in  1  detector Moore output.

## Operation
- The FSM has five states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE → CLEAR when any req bit is high.
  - Winner is the first set req at or after pointer `ptr`, wrapping.
  - The winner's word is latched into a shift register and its grant bit is set.
  - With no req, the FSM stays in IDLE.
- CLEAR: det_reset = 1 for exactly one cycle. Bit counter and hit count are cleared → SHIFT.
- SHIFT lasts W cycles.
  - det_seq_in = shift register MSB; the register shifts left each cycle.
  - det_out is sampled every SHIFT cycle; each sample of 1 increments the hit count, saturating.
  - After W cycles → DRAIN.
- DRAIN: one cycle. det_seq_in = 0. det_out is sampled once more to capture a match completed by the last bit → DONE.
- DONE: done = 1 with hit_count and match_any valid. ptr ← winner+1 mod N. grant clears on exit → IDLE.
- Requesters hold req and data until done. Data is latched at grant, so later data changes are ignored.
- Dropping req mid-transaction does not abort; the transaction completes and done is still pulsed.
- A new or re-asserted req during a busy transaction waits for IDLE. There is no preemption.
- If several reqs are simultaneous, round-robin picks one; the others wait.
- A requester re-asserting immediately after its done is served after the other pending requesters.
- Overlapping matches count, following the detector's behaviour (e.g. 1011011 = 2).

## Timing
- Reset values:
  - grant = 0, done = 0, hit_count = 0, match_any = 0.
  - det_seq_in = 0, det_reset = 0.
  - ptr = 0, FSM = IDLE.
- Reset mid-transaction returns everything to these values immediately, with no done pulse.
- Latency:
  - req seen in IDLE at cycle t → grant and det_reset high at t+1.
  - The first bit is driven at t+2.
  - done is at t+W+3.
- Transaction period is W+4 cycles (IDLE included); back-to-back requests get one IDLE cycle between transactions.
- det_out sampled in SHIFT cycle k reflects bits 0..k−1. The first SHIFT sample is 0 because the detector has just been cleared.
- hit_count and match_any hold their value after done until the next CLEAR.

## Configuration
- SEQ_SCHED_FIXED_PRIORITY_EN
  - Defined: fixed priority, where the lowest-index asserted req wins and ptr is unused, held at 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Single req[0], data 8'b1011_0110 → grant = 4'b0001 at t+1, done at t+11, hit_count = 2, match_any = 1.
- req[2], data 8'b1011_1011 → hit_count = 2; the second match is only captured in DRAIN.
- req[1], data 8'h00 → hit_count = 0, match_any = 0; 8'hB0 → hit_count = 1.
- req = 4'b1111 held continuously → grants in order 0, 1, 2, 3, 0, with a period of 12 cycles; with the macro defined → requester 0 every time.
- Reset asserted in SHIFT of requester 3 → all outputs 0 at once, no done; after release, pending req[1] is granted first (ptr = 0).
- Requester 1 drops req and changes data mid-SHIFT → transaction completes with the count for the originally latched word.
